// File: rtl/nios_setup_nios2f_cpu_ocimem_ctrl.sv
// nios_setup_nios2f_cpu_ocimem_ctrl
// Debug-side memory controller for the Nios II OCI block. Decodes the JTAG
// ocimem command strobes, arbitrates a single-port debug RAM between JTAG and
// the CPU Avalon debug slave, and maintains MonDReg / monitor_ready /
// monitor_error for JTAG shift-out.
// Optional build macro: NIOS_SETUP_OCIMEM_DEBUGACCESS_EN -- when defined, CPU
// writes only take effect with debugaccess=1 (the handshake always completes).
module nios_setup_nios2f_cpu_ocimem_ctrl #(
   parameter int RAM_DEPTH = 256,
   parameter int AW        = 8
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [37:0] jdo,
   input  logic        take_action_ocimem_a,
   input  logic        take_no_action_ocimem_a,
   input  logic        take_action_ocimem_b,
   input  logic [8:0]  address,
   input  logic        chipselect,
   input  logic        read,
   input  logic        write,
   input  logic [3:0]  byteenable,
   input  logic [31:0] writedata,
   input  logic        debugaccess,
   output logic [31:0] readdata,
   output logic        waitrequest,
   output logic [31:0] MonDReg,
   output logic        monitor_ready,
   output logic        monitor_error
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_DONE   = 2'd2
   } state_e;

   localparam logic [AW-1:0] ADDR_ONE = {{(AW-1){1'b0}}, 1'b1};

   // Registered state
   state_e         state_q, state_d;
   logic [AW-1:0]  mon_a_q, mon_a_d;
   logic [31:0]    mon_d_q, mon_d_d;
   logic           rd_pend_q, rd_pend_d;
   logic           wr_pend_q, wr_pend_d;
   logic           ready_q, ready_d;
   logic           error_q, error_d;
   logic [31:0]    readdata_q, readdata_d;
   logic           wait_q, wait_d;

   // Debug RAM (contents deliberately not reset)
   logic [31:0]    ram_q [RAM_DEPTH];

   // Arbitration and RAM port signals
   logic           jtag_pend_s;
   logic           pend_set_s;
   logic           jtag_gnt_s;
   logic           cpu_act_s;
   logic           cpu_wr_s;
   logic           cpu_reg_wr_s;
   logic           ram_we_s;
   logic [AW-1:0]  ram_addr_s;
   logic [3:0]     ram_be_s;
   logic [31:0]    ram_wdata_s;
   logic [31:0]    ram_rdata_s;
   logic [31:0]    reg_rdata_s;
   logic           unused_s;

   // Bits of the JTAG word and debugaccess that are not decoded here.
   assign unused_s = ^{jdo[37:35], jdo[2:0], debugaccess};

   // Request and grant decode; a strobe arriving this cycle already blocks a new CPU access.
   always_comb begin
      jtag_pend_s = rd_pend_q | wr_pend_q;
      pend_set_s  = (take_action_ocimem_a & jdo[34]) | take_no_action_ocimem_a
                  | take_action_ocimem_b;
      cpu_act_s   = (state_q == ST_ACCESS);
      jtag_gnt_s  = jtag_pend_s & ~cpu_act_s;
`ifdef NIOS_SETUP_OCIMEM_DEBUGACCESS_EN
      cpu_wr_s    = write & debugaccess;
`else
      cpu_wr_s    = write;
`endif
      cpu_reg_wr_s = cpu_act_s & address[8] & cpu_wr_s & (address[1:0] == 2'd0);
   end

   // RAM port mux: a JTAG grant owns the port, otherwise the CPU in ACCESS does.
   always_comb begin
      if (jtag_gnt_s) begin
         ram_addr_s  = mon_a_q;
         ram_we_s    = wr_pend_q;
         ram_be_s    = 4'hF;
         ram_wdata_s = mon_d_q;
      end else begin
         ram_addr_s  = address[AW-1:0];
         ram_we_s    = cpu_act_s & ~address[8] & cpu_wr_s;
         ram_be_s    = byteenable;
         ram_wdata_s = writedata;
      end
      ram_rdata_s = ram_q[ram_addr_s];
   end

   // Byte-lane RAM write.
   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (ram_we_s && ram_be_s[i]) begin
            ram_q[ram_addr_s][8*i +: 8] <= ram_wdata_s[8*i +: 8];
         end
      end
   end

   // JTAG address/data registers and pends: grant effects first, then the newest strobe overrides.
   always_comb begin
      mon_a_d   = mon_a_q;
      mon_d_d   = mon_d_q;
      rd_pend_d = rd_pend_q;
      wr_pend_d = wr_pend_q;
      if (jtag_gnt_s && rd_pend_q) begin
         rd_pend_d = 1'b0;
         mon_d_d   = ram_rdata_s;
      end else if (jtag_gnt_s && wr_pend_q) begin
         wr_pend_d = 1'b0;
         mon_a_d   = mon_a_q + ADDR_ONE;
      end else begin
         mon_d_d   = mon_d_q;
      end
      if (take_action_ocimem_a) begin
         mon_a_d   = jdo[AW+9:10];
         rd_pend_d = jdo[34];
         wr_pend_d = 1'b0;
      end else if (take_no_action_ocimem_a) begin
         mon_a_d   = mon_a_q + ADDR_ONE;
         rd_pend_d = 1'b1;
         wr_pend_d = 1'b0;
      end else if (take_action_ocimem_b) begin
         mon_d_d   = jdo[34:3];
         wr_pend_d = 1'b1;
         rd_pend_d = 1'b0;
      end else begin
         mon_a_d   = mon_a_d;
      end
   end

   // Monitor flags: CPU sets through register 0, a JTAG clear in the same cycle wins.
   always_comb begin
      ready_d = ready_q;
      error_d = error_q;
      if (cpu_reg_wr_s) begin
         ready_d = ready_q | writedata[0];
         error_d = error_q | writedata[1];
      end else begin
         ready_d = ready_q;
      end
      if (take_action_ocimem_a && jdo[25]) begin
         ready_d = 1'b0;
         error_d = 1'b0;
      end else begin
         error_d = error_d;
      end
   end

   // Register window read mux.
   always_comb begin
      case (address[1:0])
         2'd0:    reg_rdata_s = {30'd0, error_q, ready_q};
         2'd1:    reg_rdata_s = mon_d_q;
         2'd2:    reg_rdata_s = {{(32-AW){1'b0}}, mon_a_q};
         default: reg_rdata_s = 32'd0;
      endcase
   end

   // CPU FSM next state, read data capture and registered waitrequest.
   always_comb begin
      state_d    = state_q;
      readdata_d = readdata_q;
      case (state_q)
         ST_IDLE: begin
            if (chipselect && (read || write) && !jtag_pend_s && !pend_set_s) begin
               state_d = ST_ACCESS;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_ACCESS: begin
            state_d = ST_DONE;
            if (read) begin
               readdata_d = address[8] ? reg_rdata_s : ram_rdata_s;
            end else begin
               readdata_d = readdata_q;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
      wait_d = (state_d != ST_DONE);
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ST_IDLE;
         mon_a_q    <= {AW{1'b0}};
         mon_d_q    <= 32'd0;
         rd_pend_q  <= 1'b0;
         wr_pend_q  <= 1'b0;
         ready_q    <= 1'b0;
         error_q    <= 1'b0;
         readdata_q <= 32'd0;
         wait_q     <= 1'b1;
      end else begin
         state_q    <= state_d;
         mon_a_q    <= mon_a_d;
         mon_d_q    <= mon_d_d;
         rd_pend_q  <= rd_pend_d;
         wr_pend_q  <= wr_pend_d;
         ready_q    <= ready_d;
         error_q    <= error_d;
         readdata_q <= readdata_d;
         wait_q     <= wait_d;
      end
   end

   assign readdata      = readdata_q;
   assign waitrequest   = wait_q;
   assign MonDReg       = mon_d_q;
   assign monitor_ready = ready_q;
   assign monitor_error = error_q;

endmodule

// File: doc/nios_setup_nios2f_cpu_ocimem_ctrl.md
# nios_setup_nios2f_cpu_ocimem_ctrl

Debug-side memory controller for the Nios II on-chip instrumentation (OCI) block. It consumes the system-clock JTAG command stream (`jdo` plus `take_action_ocimem_*` strobes) and arbitrates a single-port 256x32 debug RAM between JTAG and the CPU's Avalon debug slave. It also produces `MonDReg`, `monitor_ready` and `monitor_error`, which return to the JTAG debug slave for shift-out.

## Interface
Parameters:
- `RAM_DEPTH`, 256: debug RAM words; power of two.
- `AW`, 8: word address width, equal to log2(`RAM_DEPTH`).

Ports:
- `clk` in 1: system clock; only clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `jdo` in 38: JTAG data, valid while any strobe is high.
- `take_action_ocimem_a` in 1: one-cycle address/control command.
- `take_no_action_ocimem_a` in 1: one-cycle read-continue command.
- `take_action_ocimem_b` in 1: one-cycle write command.
- `address` in 9: CPU word address. Bit 8 = 0 selects RAM; bit 8 = 1 selects the register window.
- `chipselect`, `read`, `write` in 1 each: Avalon controls.
- `byteenable` in 4: write byte lanes.
- `writedata` in 32: CPU write data.
- `debugaccess` in 1: CPU access is a debug-mode access.
- `readdata` out 32: CPU read data; valid when `waitrequest` is low.
- `waitrequest` out 1: Avalon stall.
- `MonDReg` out 32: JTAG data register.
- `monitor_ready` out 1, `monitor_error` out 1: monitor status flags.

## Operation
JTAG commands (decoded in the cycle the strobe is high):
- `take_action_ocimem_a`:
  - `MonAReg <= jdo[AW+9:10]`.
  - If `jdo[34]`, set `jtag_rd_pend`.
  - If `jdo[25]`, clear `monitor_ready` and `monitor_error`.
- `take_no_action_ocimem_a`: `MonAReg <= MonAReg+1` (wraps from `RAM_DEPTH-1` to 0) and set `jtag_rd_pend`.
- `take_action_ocimem_b`: `MonDReg <= jdo[34:3]` and set `jtag_wr_pend`.
- Strobes are mutually exclusive. Any pend already set is overwritten by the new command; the newest command wins.

Arbiter (single RAM port):
- JTAG has priority, except that a CPU access already in state ACCESS completes first.
- JTAG read grant: RAM reads `MonAReg`, pend clears, and `MonDReg` loads RAM data one cycle later.
- JTAG write grant: full-word write of `MonDReg` at `MonAReg`, pend clears, then `MonAReg <= MonAReg+1`.

CPU FSM, states IDLE, ACCESS, DONE:
- IDLE → ACCESS when `chipselect & (read|write)` and no JTAG pend.
- ACCESS: RAM or register operation executes. RAM writes honour `byteenable`.
- ACCESS → DONE: `waitrequest` drops for exactly one cycle. For reads, `readdata` is registered here.
- DONE → IDLE unconditionally.
- `waitrequest` is high in IDLE and ACCESS, low only in DONE.

Register window (`address[8]=1`, offset `address[1:0]`):
- 0: read `{30'b0, monitor_error, monitor_ready}`. Write bit0=1 sets ready; write bit1=1 sets error.
- 1: read `MonDReg`; writes ignored.
- 2: read `{(32-AW)'b0, MonAReg}`; writes ignored.
- 3: reads 0.
- Setting a flag from the CPU and clearing it from JTAG in the same cycle: the clear wins.

Reset values: `MonAReg=0`, `MonDReg=0`, `readdata=0`, `waitrequest=1`, `monitor_ready=0`, `monitor_error=0`, pends=0, FSM=IDLE. RAM contents are not reset.

## Timing
- Strobe at cycle N, RAM idle: grant at N+1, `MonDReg` valid at N+2.
- CPU in ACCESS at N+1: JTAG grant slips to N+2, `MonDReg` valid at N+3.
- CPU access with no JTAG activity: request seen at cycle M, ACCESS at M+1, DONE (`waitrequest=0`) at M+2.
- If a pend exists, the CPU waits in IDLE with `waitrequest` high until the pend clears.
- Request signals must be held stable while `waitrequest` is high.
- Reset asserted mid-access aborts immediately. No RAM write occurs after `reset_n` falls.

## Configuration
- `NIOS_SETUP_OCIMEM_DEBUGACCESS_EN` defined:
  - CPU writes (RAM and register window) take effect only if `debugaccess=1`.
  - Otherwise the write is dropped, but the handshake still completes normally.
  - CPU reads are unaffected.
- Undefined: `debugaccess` is ignored and all CPU writes take effect.

## Test plan
- Reset: hold `reset_n=0` with strobes and `chipselect` toggling → `waitrequest=1`, `MonDReg=0`, both flags 0 throughout.
- JTAG write then read:
  - `take_action_ocimem_a` with `jdo[17:10]=0x10`, `jdo[34]=0`.
  - Then `take_action_ocimem_b` with data 0xDEADBEEF → `MonAReg=0x11`.
  - Then `_a` address 0x10 with `jdo[34]=1` → `MonDReg=0xDEADBEEF` two cycles after the strobe.
- Read-continue wrap: address 0xFF with read, then `take_no_action_ocimem_a` → `MonAReg=0x00`, `MonDReg=RAM[0]`.
- Collision:
  - CPU write 0x12345678 to word 5 and a JTAG read of word 5 requested the same cycle → CPU stalls until the JTAG read completes.
  - Then the CPU write finishes → `MonDReg` holds the old value; a subsequent JTAG read returns 0x12345678.
- Byte enables: CPU writes 0xAABBCCDD with `byteenable=4'b0101` over 0 → CPU reads 0x00BB00DD; `waitrequest` low for exactly one cycle.
- Flags:
  - CPU writes 0x3 to register 0 → both flags 1.
  - JTAG `_a` with `jdo[25]=1` → both 0.
  - With the macro defined and `debugaccess=0`, the CPU write of 0x3 leaves the flags at 0.
